// File: rtl/random_pkg.sv
// Shared constants and the Galois LFSR step for the random byte source.
package random_pkg;

  localparam logic [15:0] RANDOM_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] RANDOM_DEFAULT_POLY = 16'hB400;

  // One Galois step: shift right, fold the feedback mask in when the
  // bit shifted out was set.
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s,
    input logic [15:0] poly = RANDOM_DEFAULT_POLY
  );
    logic [15:0] nxt;
    nxt = s >> 1;
    if (s[0]) nxt = nxt ^ poly;
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Galois LFSR register with a lock-up guard that reseeds from zero.
module lfsr16_core
  import random_pkg::*;
#(
  parameter logic [15:0] SEED = RANDOM_DEFAULT_SEED,
  parameter logic [15:0] POLY = RANDOM_DEFAULT_POLY
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] low
);

  logic [15:0] state;

  // Reseed on reset or from the all-zero lock-up state, otherwise step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SEED;
    end else if (state == '0) begin
      state <= SEED;
    end else begin
      state <= lfsr_step(state, POLY);
    end
  end

  assign low = state[7:0];

endmodule

// File: rtl/random.sv
// Free-running pseudo-random byte source; low byte of a 16-bit LFSR.
module random
  import random_pkg::*;
#(
  parameter logic [15:0] SEED = RANDOM_DEFAULT_SEED,
  parameter logic [15:0] POLY = RANDOM_DEFAULT_POLY
) (
  input  logic       rst,
  input  logic       clk,
  output logic [7:0] data
);

  // A zero seed would lock the LFSR, so fall back to the default seed.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? RANDOM_DEFAULT_SEED : SEED;

  lfsr16_core #(
    .SEED(SEED_EFF),
    .POLY(POLY)
  ) u_core (
    .clk(clk),
    .rst(rst),
    .low(data)
  );

endmodule

// File: tb/tb_random.sv
// Self-checking bench for the random byte source.
module tb_random;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data;
  logic [7:0] data0;

  int tests = 0;
  int fails = 0;

  logic [15:0] model;

  random #(
    .SEED(16'hACE1),
    .POLY(16'hB400)
  ) dut (
    .rst(rst),
    .clk(clk),
    .data(data)
  );

  random #(
    .SEED(16'h0000)
  ) dut0 (
    .rst(rst),
    .clk(clk),
    .data(data0)
  );

  always #5 clk = ~clk;

  // Reference next-state from the arithmetic description of the Galois step.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int unsigned v;
    int unsigned r;
    v = s;
    if (v == 0) return 16'hACE1;
    r = (v / 2) ^ (((v % 2) == 1) ? 32'h0000_B400 : 32'h0);
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    model = r ? ref_next(model) : 16'hACE1;
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"},  {8'h00, data},  {8'h00, model[7:0]});
    check({tag, "_state"}, dut.u_core.state, model);
    check({tag, "_data0"}, {8'h00, data0}, {8'h00, model[7:0]});
  endtask

  logic [15:0] exp_states [7];
  int early_bad;
  int mism;
  int len;

  initial begin
    exp_states[0] = 16'hACE1; exp_states[1] = 16'hE270; exp_states[2] = 16'h7138;
    exp_states[3] = 16'h389C; exp_states[4] = 16'h1C4E; exp_states[5] = 16'h0E27;
    exp_states[6] = 16'hB313;
    model = 16'h0000;

    // Reset then free-run against the known sequence.
    step(1'b0);
    check("reset_data", {8'h00, data}, 16'h00E1);
    check("reset_state", dut.u_core.state, 16'hACE1);
    check("reset_data0", {8'h00, data0}, 16'h00E1);
    for (int i = 1; i < 7; i++) begin
      step(1'b1);
      check("seq_state", dut.u_core.state, exp_states[i]);
      check("seq_data", {8'h00, data}, {8'h00, exp_states[i][7:0]});
      check("seq_data0", {8'h00, data0}, {8'h00, exp_states[i][7:0]});
    end

    // Mid-run reset after 10 steps.
    for (int i = 0; i < 4; i++) step(1'b1);
    check_all("run10");
    step(1'b0);
    check("midrst_data", {8'h00, data}, 16'h00E1);
    step(1'b1);
    check("midrst_next", {8'h00, data}, 16'h0070);

    // Held reset.
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      check("held_state", dut.u_core.state, 16'hACE1);
      check("held_data", {8'h00, data}, 16'h00E1);
    end

    // Randomized runs with sporadic resets.
    for (int seg = 0; seg < 20; seg++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        step($urandom_range(0, 15) != 0);
        check_all("rand");
      end
    end

    // Full period from seed.
    step(1'b0);
    early_bad = 0;
    mism = 0;
    for (int k = 1; k <= 65535; k++) begin
      step(1'b1);
      if (k < 65535 && (dut.u_core.state == 16'h0000 || dut.u_core.state == 16'hACE1))
        early_bad++;
      if (dut.u_core.state !== model || data0 !== model[7:0]) mism++;
    end
    check("period_return", dut.u_core.state, 16'hACE1);
    check("period_early", early_bad[15:0], 16'd0);
    check("period_model", mism[15:0], 16'd0);

    // Lock-up guard.
    @(negedge clk);
    rst = 1'b1;
    force dut.u_core.state = 16'h0000;
    #1;
    check("lock_forced", {8'h00, data}, 16'h0000);
    release dut.u_core.state;
    @(posedge clk);
    #1;
    check("lock_reseed", dut.u_core.state, 16'hACE1);
    step(1'b0);
    step(1'b1);
    check_all("post_lock");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
